// File: rtl/mod_out_accum.sv
// Window accumulator for the mod_out stream: buffers samples in a small FIFO,
// sums WIN of them at a time and offers each sum on a valid/ready port.
module mod_out_accum #(
  parameter int DATA_W     = 7,
  parameter int WIN        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SUM_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              drop_err,
  output logic [0:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(WIN + 1);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_valid is not backpressured upstream; a sample offered while in_ready=0
  // is lost and latches drop_err. sum_valid/sum_out stay stable until taken.

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [WC_W-1:0]   cnt_q, cnt_d;
  logic [0:0]        state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic              drop_err_q, drop_err_d;

  logic              full;
  logic              push;
  logic              pop;
  logic [SUM_W-1:0]  acc_plus;

  // Full is judged on the registered count only, so a pop on the same edge
  // never frees a slot for the incoming sample.
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign push     = in_valid && !full;
  assign pop      = (state_q == ST_ACC) && (count_q != '0);
  assign acc_plus = acc_q + SUM_W'(mem_q[rd_ptr_q]);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    drop_err_d  = drop_err_q;

    if (in_valid && full) drop_err_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_ACC: begin
        if (pop) begin
          if (cnt_q == WC_W'(WIN - 1)) begin
            sum_d       = acc_plus;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_plus;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (sum_ready) begin
          sum_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      state_q     <= ST_ACC;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready  = !full;
  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
  assign drop_err  = drop_err_q;
  assign dbg_state = state_q;

endmodule
